// File: rtl/mips_bus_unit.sv
// mips_bus_unit: Avalon-MM master arbitrating MIPS fetch and data ports.
// Define MIPS_BUS_UNIT_BIG_ENDIAN_EN for big-endian byte-lane mapping.
module mips_bus_unit #(
  parameter int ADDR_W        = 32,
  parameter int DATA_PRIORITY = 1,
  parameter int MAX_WAIT      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_data,
  output logic              if_err,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [31:0]       mem_wdata,
  output logic              mem_gnt,
  output logic              mem_valid,
  output logic [31:0]       mem_rdata,
  output logic              mem_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0] MW = MAX_WAIT;

`ifdef MIPS_BUS_UNIT_BIG_ENDIAN_EN
  localparam logic [1:0] LANE_XOR = 2'b11;
`else
  localparam logic [1:0] LANE_XOR = 2'b00;
`endif

  logic [1:0]        state;
  logic              own_if;
  logic              discard;
  logic              err_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              we_q;
  logic [31:0]       wait_cnt;

  logic              is_idle;
  logic              is_done;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic              sel_we;
  logic [1:0]        sel_ln;
  logic              misal;
  logic [3:0]        st_be;
  logic [31:0]       st_wd;
  logic              timeout;
  logic [1:0]        ld_ln;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       ld_ext;

  assign is_idle = (state == S_IDLE);
  assign is_done = (state == S_DONE);

  assign if_gnt  = is_idle && if_req &&
                   (!mem_req || DATA_PRIORITY == 0);
  assign mem_gnt = is_idle && mem_req &&
                   (!if_req || DATA_PRIORITY != 0);

  // A flush landing in the completion cycle still hides the pulse.
  assign if_valid  = is_done && own_if && !discard && !if_flush;
  assign if_err    = if_valid && err_q;
  assign mem_valid = is_done && !own_if;
  assign mem_err   = mem_valid && err_q;

  assign timeout = (MW != 32'd0) && waitrequest &&
                   (wait_cnt == MW - 32'd1);

  always_comb begin
    sel_addr = if_addr;
    sel_size = 2'd2;
    sel_we   = 1'b0;
    if (mem_gnt) begin
      sel_addr = mem_addr;
      sel_size = mem_size;
      sel_we   = mem_we;
    end
  end

  assign sel_ln = sel_addr[1:0] ^ LANE_XOR;

  always_comb begin
    misal = 1'b1;
    unique case (1'b1)
      (sel_size == 2'd0): misal = 1'b0;
      (sel_size == 2'd1): misal = sel_addr[0];
      (sel_size == 2'd2): misal = |sel_addr[1:0];
      default:            misal = 1'b1;
    endcase
  end

  always_comb begin
    st_be = 4'hF;
    st_wd = mem_wdata;
    unique case (sel_size)
      2'd0: begin
        st_be = 4'b0001 << sel_ln;
        st_wd = {4{mem_wdata[7:0]}};
      end
      2'd1: begin
        st_be = sel_ln[1] ? 4'b1100 : 4'b0011;
        st_wd = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_ln = lane_q ^ LANE_XOR;

  always_comb begin
    ld_b = readdata[7:0];
    unique case (ld_ln)
      2'd0: ld_b = readdata[7:0];
      2'd1: ld_b = readdata[15:8];
      2'd2: ld_b = readdata[23:16];
      2'd3: ld_b = readdata[31:24];
    endcase
    ld_h = ld_ln[1] ? readdata[31:16] : readdata[15:0];
    unique case (size_q)
      2'd0:    ld_ext = {{24{ld_b[7] & ~uns_q}}, ld_b};
      2'd1:    ld_ext = {{16{ld_h[15] & ~uns_q}}, ld_h};
      default: ld_ext = readdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      own_if     <= 1'b0;
      discard    <= 1'b0;
      err_q      <= 1'b0;
      lane_q     <= 2'd0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      wait_cnt   <= 32'd0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= 32'd0;
      byteenable <= 4'd0;
      if_data    <= 32'd0;
      mem_rdata  <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (if_gnt || mem_gnt) begin
            own_if   <= if_gnt;
            discard  <= 1'b0;
            err_q    <= misal;
            lane_q   <= sel_addr[1:0];
            size_q   <= sel_size;
            uns_q    <= mem_unsigned;
            we_q     <= sel_we;
            wait_cnt <= 32'd0;
            if (misal) begin
              state <= S_DONE;
              if (mem_gnt) mem_rdata <= 32'd0;
            end else begin
              state      <= S_BUS;
              address    <= {sel_addr[ADDR_W-1:2], 2'b00};
              read       <= !sel_we;
              write      <= sel_we;
              byteenable <= sel_we ? st_be : 4'hF;
              if (sel_we) writedata <= st_wd;
            end
          end
        end
        S_BUS: begin
          if ((read || write) && !waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            state <= S_RESP;
          end else if (timeout) begin
            read  <= 1'b0;
            write <= 1'b0;
            err_q <= 1'b1;
            state <= S_DONE;
            if (!own_if) mem_rdata <= 32'd0;
          end else if (waitrequest) begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_RESP: begin
          state <= S_DONE;
          if (own_if) if_data <= readdata;
          else mem_rdata <= we_q ? 32'd0 : ld_ext;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (!is_idle && own_if && if_flush) discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_bus_unit.sv
// tb_mips_bus_unit: directed plus randomized transactions checked
// against a transaction-level reference model.
module tb_mips_bus_unit;

  localparam int MAX_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_gnt, if_valid, if_err;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_we, mem_unsigned, mem_gnt, mem_valid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mips_bus_unit #(
    .ADDR_W(32),
    .DATA_PRIORITY(1),
    .MAX_WAIT(MAX_W)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_valid(if_valid), .if_data(if_data),
    .if_err(if_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One transaction from grant to completion; the model predicts bus
  // activity, completion cycle and returned data from the address rules.
  task automatic run(input bit fetch, input bit we_in,
                     input logic [31:0] addr, input logic [1:0] size,
                     input bit uns, input logic [31:0] wd, input int nwait,
                     input logic [31:0] rd, input int flush_at,
                     input bit contend);
    bit          we, mis, tmo, flushed;
    int          n, ln, hl, sz, exp_bus, exp_vc, vc, nvalid, nbus;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, v;
    we = fetch ? 1'b0 : we_in;
    sz = fetch ? 2 : int'(size);
    n  = int'(addr[1:0]);
`ifdef MIPS_BUS_UNIT_BIG_ENDIAN_EN
    ln = 3 - n;
    hl = (n == 0) ? 2 : 0;
`else
    ln = n;
    hl = n;
`endif
    mis = (sz == 3) || (sz == 2 && n != 0) || (sz == 1 && addr[0]);
    tmo = !mis && nwait >= MAX_W;
    exp_bus = mis ? 0 : (tmo ? MAX_W : nwait + 1);
    exp_vc  = mis ? 1 : (tmo ? MAX_W + 1 : nwait + 3);
    flushed = fetch && flush_at >= 1 && flush_at <= exp_vc;
    exp_be = 4'hF;
    exp_wd = wd;
    v = rd;
    if (sz == 0) begin
      exp_be = 4'b0001 << ln;
      exp_wd = {4{wd[7:0]}};
      v = (rd >> (8 * ln)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 1) begin
      exp_be = (hl == 0) ? 4'b0011 : 4'b1100;
      exp_wd = {2{wd[15:0]}};
      v = (rd >> (8 * hl)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    if (!we) exp_be = 4'hF;
    exp_rd = we ? 32'd0 : v;

    @(posedge clk); #1;
    if_req       = fetch || contend;
    if_addr      = addr;
    mem_req      = !fetch;
    mem_we       = we;
    mem_addr     = addr;
    mem_size     = size;
    mem_unsigned = uns;
    mem_wdata    = wd;
    waitrequest  = 1'b0;
    if_flush     = 1'b0;
    @(negedge clk);
    check("gnt", {30'd0, if_gnt, mem_gnt}, fetch ? 32'd2 : 32'd1);

    vc = 0; nvalid = 0; nbus = 0;
    for (int c = 1; c <= exp_vc; c++) begin
      @(posedge clk); #1;
      if (!contend) if_req = 1'b0;
      mem_req     = 1'b0;
      waitrequest = (c <= nwait);
      readdata    = (c == nwait + 2) ? rd : $urandom;
      if_flush    = (c == flush_at);
      @(negedge clk);
      if (read || write) begin
        nbus++;
        check("rw", {30'd0, read, write}, we ? 32'd1 : 32'd2);
        check("addr", address, {addr[31:2], 2'b00});
        check("be", {28'd0, byteenable}, {28'd0, exp_be});
        if (we) check("wdata", writedata, exp_wd);
      end
      if (contend) check("hold_gnt", {31'd0, if_gnt}, 32'd0);
      if (if_valid || mem_valid) begin
        nvalid++;
        if (vc == 0) vc = c;
        check("port", {30'd0, if_valid, mem_valid},
              fetch ? 32'd2 : 32'd1);
        check("err", {31'd0, fetch ? if_err : mem_err},
              {31'd0, mis || tmo});
        if (!mis && !tmo)
          check("data", fetch ? if_data : mem_rdata,
                fetch ? rd : exp_rd);
      end
    end
    check("bus_cycles", 32'(nbus), 32'(exp_bus));
    check("valid_cycle", 32'(vc), flushed ? 32'd0 : 32'(exp_vc));
    check("valid_count", 32'(nvalid), flushed ? 32'd0 : 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_size = 2'd0;
    mem_unsigned = 1'b0; mem_wdata = 32'd0;
    waitrequest = 1'b0; readdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ctl", {26'd0, read, write, if_valid, mem_valid, if_err,
          mem_err}, 32'd0);
    check("rst_addr", address, 32'd0);
    check("rst_wd", writedata, 32'd0);
    check("rst_be", {28'd0, byteenable}, 32'd0);
    check("rst_ifd", if_data, 32'd0);
    check("rst_memd", mem_rdata, 32'd0);

    run(1, 0, 32'hBFC00000, 2, 0, 0, 0, 32'h24020005, 0, 0);
    run(0, 0, 32'h00001003, 0, 0, 0, 0, 32'h80112233, 0, 0);
    run(0, 0, 32'h00001003, 0, 1, 0, 0, 32'h80112233, 0, 0);
    run(0, 1, 32'h00002002, 1, 0, 32'h0000BEEF, 3, 0, 0, 0);
    run(0, 0, 32'h00003000, 2, 0, 0, 1, 32'h12345678, 0, 1);
    run(1, 0, 32'h00000400, 2, 0, 0, 0, 32'hCAFEF00D, 0, 0);
    run(0, 0, 32'h00001002, 2, 0, 0, 0, 32'h0, 0, 0);
    run(0, 0, 32'h00004000, 2, 0, 0, 100, 32'h0, 0, 0);
    run(1, 0, 32'h00000800, 2, 0, 0, 1, 32'h11111111, 1, 0);
    run(1, 0, 32'h00000804, 2, 0, 0, 0, 32'h22222222, 0, 0);
    run(1, 0, 32'h00000806, 2, 0, 0, 0, 32'h0, 0, 0);
    run(0, 1, 32'h00000007, 0, 0, 32'h000000A5, 2, 0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      bit f;
      int fa;
      f  = ($urandom % 3) == 0;
      fa = (f && ($urandom % 4 == 0)) ? int'($urandom_range(1, 4)) : 0;
      run(f, 1'($urandom), $urandom, 2'($urandom), 1'($urandom),
          $urandom, int'($urandom % 6), $urandom, fa, 0);
    end

    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h5000;
    mem_size = 2'd2; waitrequest = 1'b1; if_req = 1'b0; if_flush = 1'b0;
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(negedge clk);
    check("mid_read", {31'd0, read}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    waitrequest = 1'b0;
    @(negedge clk);
    check("mid_drop", {30'd0, read, write}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mid_novalid", {30'd0, if_valid, mem_valid}, 32'd0);
    end
    run(1, 0, 32'h00000C00, 2, 0, 0, 0, 32'h0BADBEEF, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
